// File: rtl/jtag_debug_cmd_dispatch.sv
// System-clock side of the JTAG debug path. It synchronises the tap update strobes, captures IR and SR on
// each rising edge, and queues the captures as commands in a show-ahead FIFO with a valid/ready output.
module jtag_debug_cmd_dispatch #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            udr_async,
    input  logic                            uir_async,
    input  logic [IR_WIDTH-1:0]             ir_in,
    input  logic [SR_WIDTH-1:0]             sr,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic                            cmd_is_ir,
    output logic [IR_WIDTH-1:0]             cmd_ir,
    output logic [SR_WIDTH-1:0]             cmd_jdo,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overrun,
    input  logic                            clr_overrun
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam int EW = 1 + IR_WIDTH + SR_WIDTH;

    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_hist_q, uir_hist_q;
    logic [AW-1:0]          arm_q, arm_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overrun_q, overrun_d;
    logic                   uir_pending_q, uir_pending_d;
    logic                   udr_edge, uir_edge, push_req, do_push, do_pop, full;
    logic [EW-1:0]          push_entry;

    always_comb begin
        arm_d         = arm_q;
        udr_edge      = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q & (arm_q == '0);
        uir_edge      = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q & (arm_q == '0);
        full          = (level_q == LW'(FIFO_DEPTH));
        do_pop        = cmd_valid & cmd_ready;
        push_req      = udr_edge | uir_edge | uir_pending_q;
        do_push       = push_req & (~full | do_pop);
        push_entry    = {1'b1, ir_in, {SR_WIDTH{1'b0}}};
        uir_pending_d = 1'b0;
        if (udr_edge) begin
            // udr takes the write slot; a coincident or queued uir waits a cycle
            push_entry    = {1'b0, ir_in, sr};
            uir_pending_d = uir_pending_q | uir_edge;
        end
        overrun_d = (push_req & full & ~do_pop) | (overrun_q & ~clr_overrun);
        wr_ptr_d  = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d   = level_q + LW'(do_push) - LW'(do_pop);
        if (arm_q != '0) begin
            arm_d = arm_q - AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync_q    <= '0;
            uir_sync_q    <= '0;
            udr_hist_q    <= 1'b0;
            uir_hist_q    <= 1'b0;
            arm_q         <= AW'(SYNC_STAGES + 1);
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overrun_q     <= 1'b0;
            uir_pending_q <= 1'b0;
        end else begin
            udr_sync_q    <= {udr_sync_q[SYNC_STAGES-2:0], udr_async};
            uir_sync_q    <= {uir_sync_q[SYNC_STAGES-2:0], uir_async};
            udr_hist_q    <= udr_sync_q[SYNC_STAGES-1];
            uir_hist_q    <= uir_sync_q[SYNC_STAGES-1];
            arm_q         <= arm_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overrun_q     <= overrun_d;
            uir_pending_q <= uir_pending_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign {cmd_is_ir, cmd_ir, cmd_jdo} = mem_q[rd_ptr_q];
    assign cmd_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign overrun    = overrun_q;
endmodule
